// File: rtl/seq_div_16_8.sv
// Sequential unsigned 16/8 restoring divider, one quotient bit per clock.
// Optional macro DIV_ZERO_CHECK_EN: single-cycle divide-by-zero result with dz.
module seq_div_16_8 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic        busy,
  output logic        done,
  output logic [15:0] quotient,
  output logic [7:0]  remainder,
  output logic        dz
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [7:0]  d_q, d_d;
  logic [15:0] q_q, q_d;
  logic [7:0]  r_q, r_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic [15:0] quo_q, quo_d;
  logic [7:0]  rem_q, rem_d;

  logic [8:0]  t;
  logic        qbit;
  logic [7:0]  r_next;
  logic [15:0] q_next;

`ifdef DIV_ZERO_CHECK_EN
  logic dz_q, dz_d;
`endif

  // R < D always holds, so the partial remainder fits in 8 bits;
  // the 9th bit only matters in the trial compare.
  always_comb begin
    t      = {r_q, q_q[15]};
    qbit   = (t >= {1'b0, d_q});
    r_next = qbit ? (t[7:0] - d_q) : t[7:0];
    q_next = {q_q[14:0], qbit};
  end

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    q_d     = q_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    quo_d   = quo_q;
    rem_d   = rem_q;
`ifdef DIV_ZERO_CHECK_EN
    dz_d    = dz_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          d_d     = divisor;
          q_d     = dividend;
          r_d     = 8'd0;
          cnt_d   = 5'd16;
          state_d = S_RUN;
`ifdef DIV_ZERO_CHECK_EN
          if (divisor == 8'd0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            quo_d   = 16'hFFFF;
            rem_d   = dividend[7:0];
            dz_d    = 1'b1;
          end
`endif
        end
      end
      S_RUN: begin
        q_d   = q_next;
        r_d   = r_next;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          quo_d   = q_next;
          rem_d   = r_next;
`ifdef DIV_ZERO_CHECK_EN
          dz_d    = 1'b0;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      d_q     <= 8'd0;
      q_q     <= 16'd0;
      r_q     <= 8'd0;
      cnt_q   <= 5'd0;
      done_q  <= 1'b0;
      quo_q   <= 16'd0;
      rem_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      q_q     <= q_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
    end
  end

`ifdef DIV_ZERO_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) dz_q <= 1'b0;
    else     dz_q <= dz_d;
  end
  assign dz = dz_q;
`else
  assign dz = 1'b0;
`endif

  assign busy      = (state_q == S_RUN);
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule
